// File: rtl/fixed_point_divide_pkg.sv
// fixed_point_divide_pkg: shared types and constants for the fixed-point divider.
//   state_t          IDLE / BUSY / DONE controller states
//   DEF_Q_BITS       default fractional bits
//   DEF_D_WIDTH      default operand/result width
//   W, CNT_W         iteration count and counter width at the defaults
//   MAX_POS/MAX_NEG  saturation values at the default width
package fixed_point_divide_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int DEF_Q_BITS = 10;
    localparam int DEF_D_WIDTH = 32;
    localparam int W = DEF_D_WIDTH + DEF_Q_BITS;
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [DEF_D_WIDTH-1:0] MAX_POS = {1'b0, {(DEF_D_WIDTH-1){1'b1}}};
    localparam logic [DEF_D_WIDTH-1:0] MAX_NEG = {1'b1, {(DEF_D_WIDTH-1){1'b0}}};
endpackage

// File: rtl/fixed_point_divide_if.sv
// fixed_point_divide_if: operand/result handshake for the divider.
//   dividend, divisor, valid_in   master -> slave
//   quotient, remainder, valid_out slave -> master
interface fixed_point_divide_if #(parameter int D_WIDTH = 32);
    logic [D_WIDTH-1:0] dividend;
    logic [D_WIDTH-1:0] divisor;
    logic               valid_in;
    logic [D_WIDTH-1:0] quotient;
    logic [D_WIDTH-1:0] remainder;
    logic               valid_out;
    modport master (output dividend, divisor, valid_in, input quotient, remainder, valid_out);
    modport slave (input dividend, divisor, valid_in, output quotient, remainder, valid_out);
endinterface

// File: rtl/fixed_point_divide.sv
// fixed_point_divide: signed Q-format restoring divider, one quotient bit per cycle.
//   clock  rising-edge clock
//   reset  synchronous active-low reset
//   bus    slave side of fixed_point_divide_if (operands in, quotient/remainder/valid_out)
module fixed_point_divide
    import fixed_point_divide_pkg::*;
#(
    parameter int Q_BITS = DEF_Q_BITS,
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input logic clock,
    input logic reset,
    fixed_point_divide_if.slave bus
);
    localparam int WL = D_WIDTH + Q_BITS;
    localparam int CW = $clog2(WL + 1);
    localparam logic [WL-1:0] Q_MIN = WL'(1) << (D_WIDTH - 1);
    localparam logic [D_WIDTH-1:0] SAT_POS = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] SAT_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WL-1:0]      n_reg;
    logic [WL-1:0]      quo;
    logic [D_WIDTH-1:0] rem;
    logic [D_WIDTH-1:0] d_reg;
    logic [D_WIDTH-1:0] a_reg;
    logic               neg;
    logic               zero;

    logic [D_WIDTH-1:0] a_mag, d_mag, q_out, r_out;
    logic [D_WIDTH:0]   r_sh, r_sub;
    logic               ge, over, sat;

    always_comb begin
        a_mag = bus.dividend[D_WIDTH-1] ? -bus.dividend : bus.dividend;
        d_mag = bus.divisor[D_WIDTH-1] ? -bus.divisor : bus.divisor;
        r_sh  = {rem, n_reg[WL-1]};
        r_sub = r_sh - {1'b0, d_reg};
        ge    = r_sh >= {1'b0, d_reg};
        // a negative result may reach one step further, down to the most negative value
        over  = |quo[WL-1:D_WIDTH-1];
        sat   = neg ? (over && quo != Q_MIN) : over;
        q_out = zero ? (a_reg[D_WIDTH-1] ? SAT_NEG : SAT_POS)
              : sat  ? (neg ? SAT_NEG : SAT_POS)
              : neg  ? -quo[D_WIDTH-1:0] : quo[D_WIDTH-1:0];
        r_out = zero ? a_reg : sat ? '0 : a_reg[D_WIDTH-1] ? -rem : rem;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            n_reg         <= '0;
            quo           <= '0;
            rem           <= '0;
            d_reg         <= '0;
            a_reg         <= '0;
            neg           <= 1'b0;
            zero          <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            case (state)
                IDLE: if (bus.valid_in) begin
                    n_reg <= WL'(a_mag) << Q_BITS;
                    d_reg <= d_mag;
                    a_reg <= bus.dividend;
                    neg   <= bus.dividend[D_WIDTH-1] ^ bus.divisor[D_WIDTH-1];
                    zero  <= bus.divisor == '0;
                    quo   <= '0;
                    rem   <= '0;
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    rem   <= ge ? r_sub[D_WIDTH-1:0] : r_sh[D_WIDTH-1:0];
                    quo   <= {quo[WL-2:0], ge};
                    n_reg <= n_reg << 1;
                    cnt   <= cnt + 1'b1;
                    state <= cnt == CW'(WL - 1) ? DONE : BUSY;
                end
                default: begin
                    bus.quotient  <= q_out;
                    bus.remainder <= r_out;
                    bus.valid_out <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_divide.sv
// tb_fixed_point_divide: directed-vector bench for fixed_point_divide.
module tb_fixed_point_divide;
    import fixed_point_divide_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fixed_point_divide_if #(.D_WIDTH(DEF_D_WIDTH)) bus ();

    fixed_point_divide #(.Q_BITS(DEF_Q_BITS), .D_WIDTH(DEF_D_WIDTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_div(string tag, logic [31:0] a, logic [31:0] b, logic [31:0] eq, logic [31:0] er);
        int lat = 0;
        @(negedge clock);
        bus.dividend = a;
        bus.divisor  = b;
        bus.valid_in = 1'b1;
        @(posedge clock);
        #1 bus.valid_in = 1'b0;
        for (int c = 1; c <= W + 20; c++) begin
            @(posedge clock);
            #1;
            if (bus.valid_out) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, lat, W + 1);
        check({tag, " quotient"}, bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        @(posedge clock);
        #1 check({tag, " pulse width"}, {31'd0, bus.valid_out}, 32'd0);
    endtask

    initial begin
        int pulses;
        int t0;
        int t1;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.valid_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset quotient", bus.quotient, 32'd0);
        check("reset remainder", bus.remainder, 32'd0);
        check("reset valid_out", {31'd0, bus.valid_out}, 32'd0);
        @(negedge clock) reset = 1'b1;

        run_div("pos/pos", 32'd194560, 32'd7168, 32'd27794, 32'd2048);
        run_div("neg/pos", -32'd194560, 32'd7168, -32'd27794, -32'd2048);
        run_div("pos/neg", 32'd194560, -32'd7168, -32'd27794, 32'd2048);
        run_div("div0 pos", 32'd5120, 32'd0, MAX_POS, 32'd5120);
        run_div("div0 neg", -32'd5120, 32'd0, MAX_NEG, -32'd5120);
        run_div("ovf pos", 32'h4000_0000, 32'd1, MAX_POS, 32'd0);
        run_div("ovf neg", -32'h4000_0000, 32'd1, MAX_NEG, 32'd0);
        run_div("edge neg min", -32'h0020_0000, 32'd1, 32'h8000_0000, 32'd0);
        run_div("edge pos sat", 32'h0020_0000, 32'd1, MAX_POS, 32'd0);
        run_div("min/min", 32'h8000_0000, 32'h8000_0000, 32'd1024, 32'd0);
        run_div("one third", 32'd1, 32'd3, 32'd341, 32'd1);
        run_div("neg third", -32'd1, 32'd3, -32'd341, -32'd1);
        run_div("exact", 32'd3072, 32'd2048, 32'd1536, 32'd0);

        // abort a division in flight
        @(negedge clock);
        bus.dividend = 32'd194560;
        bus.divisor  = 32'd7168;
        bus.valid_in = 1'b1;
        @(posedge clock);
        #1 bus.valid_in = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        check("abort quotient", bus.quotient, 32'd0);
        check("abort remainder", bus.remainder, 32'd0);
        @(negedge clock) reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < W + 20; c++) begin
            @(posedge clock);
            #1 if (bus.valid_out) pulses++;
        end
        check("abort no pulse", pulses, 32'd0);

        // held valid_in: operands changed during BUSY belong to the next division
        @(negedge clock);
        bus.dividend = 32'd194560;
        bus.divisor  = 32'd7168;
        bus.valid_in = 1'b1;
        @(posedge clock);
        #1;
        bus.dividend = 32'd3072;
        bus.divisor  = 32'd2048;
        pulses = 0;
        t0 = 0;
        t1 = 0;
        for (int c = 1; c <= 200 && pulses < 2; c++) begin
            @(posedge clock);
            #1;
            if (bus.valid_out) begin
                if (pulses == 0) begin
                    t0 = c;
                    check("held first quotient", bus.quotient, 32'd27794);
                    check("held first remainder", bus.remainder, 32'd2048);
                end else begin
                    t1 = c;
                    bus.valid_in = 1'b0;
                    check("held second quotient", bus.quotient, 32'd1536);
                    check("held second remainder", bus.remainder, 32'd0);
                end
                pulses++;
            end
        end
        bus.valid_in = 1'b0;
        check("held pulse count", pulses, 32'd2);
        check("held first latency", t0, W + 1);
        check("held interval", t1 - t0, W + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
